// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU signal bundle for alu_share_arbiter.
// Latency: none (wires only).
// Backpressure: carried by the req_ready and resp_ready signals inside the bundle.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    // Request channels (two requesters)
    logic             req_valid0;
    logic             req_valid1;
    logic             req_ready0;
    logic             req_ready1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic [3:0]       req_ctrl0;
    logic [3:0]       req_ctrl1;
    logic             req_arith0;
    logic             req_arith1;

    // Response channels (data and flags are shared by both)
    logic             resp_valid0;
    logic             resp_valid1;
    logic             resp_ready0;
    logic             resp_ready1;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic             resp_less;
    logic             resp_lessu;

    // Shared combinational ALU
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic             alu_shift_arith;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_less;
    logic             alu_lessu;

    // Arbiter side
    modport slave (
        input  req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
               req_ctrl0, req_ctrl1, req_arith0, req_arith1,
               resp_ready0, resp_ready1,
               alu_out, alu_zero, alu_less, alu_lessu,
        output req_ready0, req_ready1,
               resp_valid0, resp_valid1, resp_data, resp_zero, resp_less, resp_lessu,
               alu_a, alu_b, alu_ctrl, alu_shift_arith
    );

    // Requester and ALU side
    modport master (
        output req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
               req_ctrl0, req_ctrl1, req_arith0, req_arith1,
               resp_ready0, resp_ready1,
               alu_out, alu_zero, alu_less, alu_lessu,
        input  req_ready0, req_ready1,
               resp_valid0, resp_valid1, resp_data, resp_zero, resp_less, resp_lessu,
               alu_a, alu_b, alu_ctrl, alu_shift_arith
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Latency: result valid exactly 1 cycle after the request handshake; 1 op/cycle.
// Backpressure: a held result whose owner is not ready blocks new grants on both ports.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             less_q;
    logic             lessu_q;

    logic             owner_rdy;
    logic             accept;
    logic             grant0;
    logic             grant1;

    // The result slot frees up either when empty or when its owner drains it this cycle
    assign owner_rdy = owner ? bus.resp_ready1 : bus.resp_ready0;
    assign accept    = (state == IDLE) || owner_rdy;

    // Round-robin pick inside the accept window; on conflict the port not served last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (accept) begin
            if (bus.req_valid0 && bus.req_valid1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req_valid0;
                grant1 = bus.req_valid1;
            end
        end
    end

    // Steer the granted port's operands to the ALU; quiet zeros when nobody is granted
    always_comb begin
        bus.alu_a           = '0;
        bus.alu_b           = '0;
        bus.alu_ctrl        = 4'b0000;
        bus.alu_shift_arith = 1'b0;
        if (grant0) begin
            bus.alu_a           = bus.req_a0;
            bus.alu_b           = bus.req_b0;
            bus.alu_ctrl        = bus.req_ctrl0;
            bus.alu_shift_arith = bus.req_arith0;
        end else if (grant1) begin
            bus.alu_a           = bus.req_a1;
            bus.alu_b           = bus.req_b1;
            bus.alu_ctrl        = bus.req_ctrl1;
            bus.alu_shift_arith = bus.req_arith1;
        end
    end

    // FSM plus result register: capture ALU output on a grant, release on owner handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            data_q     <= '0;
            zero_q     <= 1'b0;
            less_q     <= 1'b0;
            lessu_q    <= 1'b0;
        end else if (grant0 || grant1) begin
            state      <= HOLD;
            owner      <= grant1;
            last_grant <= grant1;
            data_q     <= bus.alu_out;
            zero_q     <= bus.alu_zero;
            less_q     <= bus.alu_less;
            lessu_q    <= bus.alu_lessu;
        end else if (state == HOLD && owner_rdy) begin
            state <= IDLE;
        end
    end

    assign bus.req_ready0  = grant0;
    assign bus.req_ready1  = grant1;
    assign bus.resp_valid0 = (state == HOLD) && !owner;
    assign bus.resp_valid1 = (state == HOLD) && owner;
    assign bus.resp_data   = data_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_less   = less_q;
    assign bus.resp_lessu  = lessu_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU attached.
// Latency: expects responses one cycle after each request handshake.
// Backpressure: exercises owner stalls, drain-and-refill and non-owner readiness.
module tb_alu_share_arbiter;
    localparam int W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SR   = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         less;
        logic         lessu;
    } exp_t;

    typedef struct {
        logic         port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   ctrl;
        logic         arith;
        logic [W-1:0] exp_data;
        logic         exp_zero;
        logic         exp_less;
        logic         exp_lessu;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural model of the shared combinational ALU
    logic [W-1:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (bus.alu_ctrl)
            OP_ADD:  alu_r = bus.alu_a + bus.alu_b;
            OP_SUB:  alu_r = bus.alu_a - bus.alu_b;
            OP_AND:  alu_r = bus.alu_a & bus.alu_b;
            OP_OR:   alu_r = bus.alu_a | bus.alu_b;
            OP_XOR:  alu_r = bus.alu_a ^ bus.alu_b;
            OP_SLL:  alu_r = bus.alu_a << bus.alu_b[4:0];
            OP_SR:   alu_r = bus.alu_shift_arith ? W'($signed(bus.alu_a) >>> bus.alu_b[4:0])
                                                 : bus.alu_a >> bus.alu_b[4:0];
            OP_SLT:  alu_r = {{(W-1){1'b0}}, $signed(bus.alu_a) < $signed(bus.alu_b)};
            OP_SLTU: alu_r = {{(W-1){1'b0}}, bus.alu_a < bus.alu_b};
            default: alu_r = '0;
        endcase
    end
    assign bus.alu_out   = alu_r;
    assign bus.alu_zero  = (alu_r == '0);
    assign bus.alu_less  = $signed(bus.alu_a) < $signed(bus.alu_b);
    assign bus.alu_lessu = bus.alu_a < bus.alu_b;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t cur_exp[2];
    logic mdl_hold, mdl_owner, nxt_hold, nxt_owner;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] ctrl, input logic arith, input logic [W-1:0] ed,
                           input logic ez, input logic el, input logic elu);
        if (p == 0) begin
            bus.req_valid0 = v; bus.req_a0 = a; bus.req_b0 = b;
            bus.req_ctrl0 = ctrl; bus.req_arith0 = arith;
        end else begin
            bus.req_valid1 = v; bus.req_a1 = a; bus.req_b1 = b;
            bus.req_ctrl1 = ctrl; bus.req_arith1 = arith;
        end
        cur_exp[p] = '{ed, ez, el, elu};
    endtask

    task automatic idle_req(input int p);
        set_req(p, 1'b0, '0, '0, 4'b0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle sampling: grant check, response-valid check, scoreboard pop/push
    task automatic sample(input logic [1:0] exp_rdy, input string tag);
        logic [1:0] ev;
        logic       ordy;
        exp_t       e;
        #4;
        chk({tag, " req_ready"}, {bus.req_ready1, bus.req_ready0}, exp_rdy);
        ev = mdl_hold ? (mdl_owner ? 2'b10 : 2'b01) : 2'b00;
        chk({tag, " resp_valid"}, {bus.resp_valid1, bus.resp_valid0}, ev);
        ordy      = mdl_owner ? bus.resp_ready1 : bus.resp_ready0;
        nxt_hold  = mdl_hold;
        nxt_owner = mdl_owner;
        if (mdl_hold && ordy) begin
            nxt_hold = 1'b0;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard: got response with empty queue, expected none", tag);
            end else begin
                e = sb_q.pop_front();
                chk({tag, " resp_data"}, bus.resp_data, e.data);
                chk({tag, " resp_flags"}, {bus.resp_zero, bus.resp_less, bus.resp_lessu},
                    {e.zero, e.less, e.lessu});
            end
        end
        if (bus.req_ready0 || bus.req_ready1) begin
            sb_q.push_back(cur_exp[bus.req_ready1 ? 1 : 0]);
            nxt_hold  = 1'b1;
            nxt_owner = bus.req_ready1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        mdl_hold  = nxt_hold;
        mdl_owner = nxt_owner;
    endtask

    task automatic cycle(input logic [1:0] exp_rdy, input string tag);
        sample(exp_rdy, tag);
        adv();
    endtask

    task automatic model_clear();
        sb_q.delete();
        mdl_hold  = 1'b0;
        mdl_owner = 1'b0;
        nxt_hold  = 1'b0;
        nxt_owner = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_req(0);
        idle_req(1);
        bus.resp_ready0 = 1'b0;
        bus.resp_ready1 = 1'b0;
        model_clear();

        vecs[0] = '{1'b0, 32'd5,         32'd7,         OP_ADD, 1'b0, 32'd12,        1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 32'd9,         32'd9,         OP_SUB, 1'b0, 32'd0,         1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFFFFFF,  32'd1,         OP_SLT, 1'b0, 32'd1,         1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h000000F0,  32'h0000000F,  OP_XOR, 1'b0, 32'h000000FF,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000,  32'd4,         OP_SR,  1'b1, 32'hF8000000,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h80000000,  32'd4,         OP_SR,  1'b0, 32'h08000000,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0000FF00,  32'h00000FF0,  OP_AND, 1'b0, 32'h00000F00,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'd3,         32'd5,         OP_SUB, 1'b0, 32'hFFFFFFFE,  1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst resp_valid", {bus.resp_valid1, bus.resp_valid0}, 2'b00);
        chk("rst resp_data", bus.resp_data, 32'd0);
        chk("rst flags", {bus.resp_zero, bus.resp_less, bus.resp_lessu}, 3'b000);
        chk("rst req_ready", {bus.req_ready1, bus.req_ready0}, 2'b00);
        reset = 1'b0;

        // Table of single-port operations, back to back, responses always taken
        bus.resp_ready0 = 1'b1;
        bus.resp_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle_req(vecs[i].port ? 0 : 1);
            set_req(vecs[i].port ? 1 : 0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].arith,
                    vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_less, vecs[i].exp_lessu);
            sample(vecs[i].port ? 2'b10 : 2'b01, "vec");
            chk("vec alu_a", bus.alu_a, vecs[i].a);
            chk("vec alu_b", bus.alu_b, vecs[i].b);
            chk("vec alu_ctrl", bus.alu_ctrl, vecs[i].ctrl);
            chk("vec alu_shift_arith", bus.alu_shift_arith, vecs[i].arith);
            adv();
        end
        idle_req(0);
        idle_req(1);
        cycle(2'b00, "vec drain");

        // Continuous conflict: grants alternate 0,1,0,1
        set_req(0, 1'b1, 32'd9, 32'd9, OP_SUB, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        set_req(1, 1'b1, 32'hFFFFFFFF, 32'd1, OP_SLT, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle((i % 2 == 0) ? 2'b01 : 2'b10, "alt");
        idle_req(0);
        idle_req(1);
        cycle(2'b00, "alt drain");

        // Owner stall blocks port 1; non-owner readiness ignored
        set_req(0, 1'b1, 32'h000000F0, 32'h0000000F, OP_XOR, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b1, 32'h80000000, 32'd4, OP_SR, 1'b1, 32'hF8000000, 1'b0, 1'b1, 1'b0);
        bus.resp_ready0 = 1'b0;
        cycle(2'b01, "bp grant");
        idle_req(0);
        for (int i = 0; i < 3; i++) begin
            sample(2'b00, "bp hold");
            chk("bp held data", bus.resp_data, 32'h000000FF);
            adv();
        end
        bus.resp_ready0 = 1'b1;
        sample(2'b10, "bp release");
        chk("bp alu_shift_arith", bus.alu_shift_arith, 1'b1);
        adv();
        idle_req(1);
        cycle(2'b00, "bp p1 result");

        // No requests: ALU inputs quiet, nothing granted, nothing valid
        for (int i = 0; i < 4; i++) begin
            sample(2'b00, "idle");
            chk("idle alu_a", bus.alu_a, 32'd0);
            chk("idle alu_b", bus.alu_b, 32'd0);
            chk("idle alu_ctrl", bus.alu_ctrl, 4'd0);
            chk("idle alu_shift_arith", bus.alu_shift_arith, 1'b0);
            adv();
        end

        // Asynchronous reset while port 1 holds 0x55
        set_req(1, 1'b1, 32'h50, 32'h5, OP_ADD, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
        bus.resp_ready1 = 1'b0;
        cycle(2'b10, "hold grant");
        idle_req(1);
        sample(2'b00, "hold");
        chk("hold data", bus.resp_data, 32'h55);
        reset = 1'b1;
        #1;
        chk("async rst resp_valid", {bus.resp_valid1, bus.resp_valid0}, 2'b00);
        chk("async rst resp_data", bus.resp_data, 32'd0);
        chk("async rst flags", {bus.resp_zero, bus.resp_less, bus.resp_lessu}, 3'b000);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.resp_ready0 = 1'b1;
        bus.resp_ready1 = 1'b1;
        set_req(0, 1'b1, 32'd2, 32'd3, OP_ADD, 1'b0, 32'd5, 1'b0, 1'b1, 1'b1);
        set_req(1, 1'b1, 32'd10, 32'd20, OP_ADD, 1'b0, 32'd30, 1'b0, 1'b1, 1'b1);
        cycle(2'b01, "post rst arb");
        idle_req(0);
        idle_req(1);
        cycle(2'b00, "post rst drain");

        // Reset in IDLE after port 0 was served last: port 0 must still win the first conflict
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(0, 1'b1, 32'd2, 32'd3, OP_ADD, 1'b0, 32'd5, 1'b0, 1'b1, 1'b1);
        set_req(1, 1'b1, 32'd10, 32'd20, OP_ADD, 1'b0, 32'd30, 1'b0, 1'b1, 1'b1);
        cycle(2'b01, "rst2 arb");
        idle_req(0);
        cycle(2'b10, "rst2 p1");
        idle_req(1);
        cycle(2'b00, "rst2 drain");

        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
